// File: rtl/map_line_writer.sv
// rtl/map_line_writer.sv - Bresenham line/clear writer feeding port A of the VGA map BRAM
module map_line_writer #(
    parameter int         H_RES    = 640,
    parameter int         V_RES    = 480,
    parameter logic [7:0] FREE_VAL = 8'h00,
    parameter logic [7:0] OBST_VAL = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  origin_x,
    input  logic [8:0]  origin_y,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    input  logic        pt_valid,
    output logic        pt_ready,
    input  logic        clear_req,
    output logic [18:0] vga_waddr,
    output logic [7:0]  dina,
    output logic        wea,
    output logic        busy,
    output logic        line_done,
    output logic        clear_done,
    output logic        oob_err
);

    localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
    localparam logic [10:0] X_LIM     = 11'(H_RES);
    localparam logic [9:0]  Y_LIM     = 10'(V_RES);

    typedef enum logic [1:0] {IDLE, CLEAR, SETUP, DRAW} state_t;

    state_t            state;
    logic [9:0]        cx, x1;
    logic [8:0]        cy, y1;
    logic signed [11:0] dx, dy, err;
    logic              sx_neg, sy_neg;

    logic signed [11:0] ddx, ddy, dx_c, dy_c, err_n;
    logic signed [12:0] e2;
    logic              step_x, step_y, at_end, next_end, pt_oob;
    logic [9:0]        nx;
    logic [8:0]        ny;

    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        return ({10'd0, y} << 9) + ({10'd0, y} << 7) + {9'd0, x};
    endfunction

    assign pt_ready = (state == IDLE) && !clear_req;
    assign busy     = (state != IDLE);
    assign pt_oob   = ({1'b0, pt_x} >= X_LIM) || ({1'b0, pt_y} >= Y_LIM);

    // The registered write always reflects (cx,cy); the next pixel is computed from the pre-update err.
    always_comb begin
        ddx      = $signed({2'b00, x1}) - $signed({2'b00, cx});
        ddy      = $signed({3'b000, y1}) - $signed({3'b000, cy});
        dx_c     = (ddx < 0) ? -ddx : ddx;
        dy_c     = (ddy < 0) ? ddy : -ddy;
        e2       = $signed({err, 1'b0});
        step_x   = (e2 >= $signed({dy[11], dy}));
        step_y   = (e2 <= $signed({dx[11], dx}));
        err_n    = err + (step_x ? dy : 12'sd0) + (step_y ? dx : 12'sd0);
        nx       = step_x ? (sx_neg ? cx - 10'd1 : cx + 10'd1) : cx;
        ny       = step_y ? (sy_neg ? cy - 9'd1 : cy + 9'd1) : cy;
        at_end   = (cx == x1) && (cy == y1);
        next_end = (nx == x1) && (ny == y1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wea        <= 1'b0;
            vga_waddr  <= '0;
            dina       <= '0;
            line_done  <= 1'b0;
            clear_done <= 1'b0;
            oob_err    <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            x1         <= '0;
            y1         <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
        end else begin
            wea        <= 1'b0;
            line_done  <= 1'b0;
            clear_done <= 1'b0;
            oob_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        wea       <= 1'b1;
                        vga_waddr <= '0;
                        dina      <= FREE_VAL;
                    end else if (pt_valid) begin
                        cx <= origin_x;
                        cy <= origin_y;
                        x1 <= pt_x;
                        y1 <= pt_y;
                        if (pt_oob) oob_err <= 1'b1;
                        else        state   <= SETUP;
                    end
                end
                CLEAR: begin
                    if (vga_waddr == LAST_ADDR) begin
                        state <= IDLE;
                    end else begin
                        wea        <= 1'b1;
                        vga_waddr  <= vga_waddr + 19'd1;
                        dina       <= FREE_VAL;
                        clear_done <= (vga_waddr + 19'd1 == LAST_ADDR);
                    end
                end
                SETUP: begin
                    dx        <= dx_c;
                    dy        <= dy_c;
                    err       <= dx_c + dy_c;
                    sx_neg    <= !(cx < x1);
                    sy_neg    <= !(cy < y1);
                    wea       <= 1'b1;
                    vga_waddr <= pix_addr(cx, cy);
                    dina      <= at_end ? OBST_VAL : FREE_VAL;
                    line_done <= at_end;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (at_end) begin
                        state <= IDLE;
                    end else begin
                        cx        <= nx;
                        cy        <= ny;
                        err       <= err_n;
                        wea       <= 1'b1;
                        vga_waddr <= pix_addr(nx, ny);
                        dina      <= next_end ? OBST_VAL : FREE_VAL;
                        line_done <= next_end;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_line_writer.sv
// tb/tb_map_line_writer.sv - directed table-driven bench for map_line_writer
module tb_map_line_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  origin_x, pt_x;
    logic [8:0]  origin_y, pt_y;
    logic        pt_valid, clear_req;
    logic        pt_ready, wea, busy, line_done, clear_done, oob_err;
    logic [18:0] vga_waddr;
    logic [7:0]  dina;

    logic        s_clear_req, s_pt_valid;
    logic        s_pt_ready, s_wea, s_busy, s_line_done, s_clear_done, s_oob_err;
    logic [18:0] s_waddr;
    logic [7:0]  s_dina;

    always #5 clk = ~clk;

    map_line_writer dut (
        .clk(clk), .reset(reset), .origin_x(origin_x), .origin_y(origin_y),
        .pt_x(pt_x), .pt_y(pt_y), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .clear_req(clear_req), .vga_waddr(vga_waddr), .dina(dina), .wea(wea),
        .busy(busy), .line_done(line_done), .clear_done(clear_done), .oob_err(oob_err)
    );

    // Short map so a complete clear fits in a brief run
    map_line_writer #(.H_RES(640), .V_RES(2)) dut_small (
        .clk(clk), .reset(reset), .origin_x(origin_x), .origin_y(origin_y),
        .pt_x(pt_x), .pt_y(pt_y), .pt_valid(s_pt_valid), .pt_ready(s_pt_ready),
        .clear_req(s_clear_req), .vga_waddr(s_waddr), .dina(s_dina), .wea(s_wea),
        .busy(s_busy), .line_done(s_line_done), .clear_done(s_clear_done), .oob_err(s_oob_err)
    );

    typedef struct {
        int ox, oy, px, py;
        int n, first, last;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    int cap_addr[$];
    int cap_data[$];
    int cap_cyc[$];
    int ld_cnt, ld_last, oob_cnt, oob_cyc, low_cnt, timed_out;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!pt_ready && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
        if (!pt_ready) check("ready_wait", 0, 1);
    endtask

    task automatic run_point(input int ox, input int oy, input int px, input int py);
        int c;
        wait_ready();
        origin_x = 10'(ox); origin_y = 9'(oy);
        pt_x     = 10'(px); pt_y     = 9'(py);
        pt_valid = 1'b1;
        @(posedge clk); #1;
        pt_valid = 1'b0;
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
        ld_cnt = 0; ld_last = 0; oob_cnt = 0; oob_cyc = -1; low_cnt = 0;
        for (c = 1; c <= 1000; c++) begin
            if (wea) begin
                cap_addr.push_back(int'(vga_waddr));
                cap_data.push_back(int'(dina));
                cap_cyc.push_back(c);
                ld_last = int'(line_done);
            end
            if (line_done) ld_cnt++;
            if (oob_err) begin oob_cnt++; oob_cyc = c; end
            if (pt_ready) break;
            low_cnt++;
            @(posedge clk); #1;
        end
        timed_out = (c > 1000) ? 1 : 0;
    endtask

    task automatic check_vec(input vec_t v);
        int bad = 0;
        int n   = cap_addr.size();
        check("timeout", timed_out, 0);
        check("n_writes", n, v.n);
        if (v.n > 0 && n > 0) begin
            check("first_addr", cap_addr[0], v.first);
            check("last_addr", cap_addr[n-1], v.last);
            check("last_data", cap_data[n-1], 255);
            for (int i = 0; i < n - 1; i++) if (cap_data[i] != 0) bad++;
            check("free_data", bad, 0);
            check("first_cycle", cap_cyc[0], 2);
            check("no_gaps", cap_cyc[n-1] - cap_cyc[0], n - 1);
            check("line_done_cnt", ld_cnt, 1);
            check("line_done_last", ld_last, 1);
            check("ready_low", low_cnt, v.n + 1);
            check("no_oob", oob_cnt, 0);
        end else begin
            check("oob_cnt", oob_cnt, 1);
            check("oob_cycle", oob_cyc, 1);
            check("oob_ready_low", low_cnt, 0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int bad, ld, cnt, cd_cnt, cd_addr, first_cyc;

        vecs[0] = '{321, 265, 325, 265, 5, 169921, 169925};
        vecs[1] = '{321, 265, 318, 262, 4, 169921, 167998};
        vecs[2] = '{321, 265, 322, 270, 6, 169921, 173122};
        vecs[3] = '{321, 265, 321, 265, 1, 169921, 169921};
        vecs[4] = '{321, 265, 640,  10, 0, 0, 0};
        vecs[5] = '{321, 265,  10, 480, 0, 0, 0};
        vecs[6] = '{  0,   0, 639, 479, 640, 0, 307199};
        vecs[7] = '{ 10,  10,   0,   0, 11, 6410, 0};

        reset = 1'b1; pt_valid = 1'b0; clear_req = 1'b0;
        s_clear_req = 1'b0; s_pt_valid = 1'b0;
        origin_x = '0; origin_y = '0; pt_x = '0; pt_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wea", int'(wea), 0);
        check("rst_addr", int'(vga_waddr), 0);
        check("rst_dina", int'(dina), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({line_done, clear_done, oob_err}), 0);
        reset = 1'b0;
        #1;
        check("rst_ready", int'(pt_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_point(vecs[i].ox, vecs[i].oy, vecs[i].px, vecs[i].py);
            check_vec(vecs[i]);
        end

        run_point(321, 265, 318, 262);
        if (cap_addr.size() == 4) begin
            check("diag_addr1", cap_addr[1], 169280);
            check("diag_addr2", cap_addr[2], 168639);
        end else check("diag_size", cap_addr.size(), 4);

        // Reset during the third write of a 100-pixel line
        wait_ready();
        origin_x = 10'd321; origin_y = 9'd265; pt_x = 10'd420; pt_y = 9'd265;
        pt_valid = 1'b1;
        @(posedge clk); #1;
        pt_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_wea", int'(wea), 1);
        check("mid_addr", int'(vga_waddr), 169923);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_wea", int'(wea), 0);
        check("abort_busy", int'(busy), 0);
        #1;
        check("abort_ready", int'(pt_ready), 1);
        cnt = 0;
        repeat (5) begin @(posedge clk); #1; if (wea) cnt++; end
        check("abort_quiet", cnt, 0);
        run_point(vecs[0].ox, vecs[0].oy, vecs[0].px, vecs[0].py);
        check_vec(vecs[0]);

        // Clear request wins over a simultaneous point
        wait_ready();
        origin_x = 10'd321; origin_y = 9'd265; pt_x = 10'd330; pt_y = 9'd265;
        clear_req = 1'b1; pt_valid = 1'b1;
        #1;
        check("clr_pri_ready", int'(pt_ready), 0);
        @(posedge clk); #1;
        clear_req = 1'b0; pt_valid = 1'b0;
        check("clr_first_wea", int'(wea), 1);
        check("clr_first_addr", int'(vga_waddr), 0);
        check("clr_busy", int'(busy), 1);
        bad = 0; ld = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!wea || int'(vga_waddr) != i || dina != 8'h00) bad++;
            if (line_done || oob_err || clear_done) ld++;
            @(posedge clk); #1;
        end
        check("clr_seq", bad, 0);
        check("clr_no_line", ld, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("clr_abort_wea", int'(wea), 0);

        // Full clear on the short map
        s_clear_req = 1'b1;
        @(posedge clk); #1;
        s_clear_req = 1'b0;
        cnt = 0; bad = 0; cd_cnt = 0; cd_addr = -1; first_cyc = -1;
        for (int i = 0; i < 1500; i++) begin
            if (s_wea) begin
                if (first_cyc < 0) first_cyc = i;
                if (int'(s_waddr) != cnt || s_dina != 8'h00) bad++;
                cnt++;
            end
            if (s_clear_done) begin cd_cnt++; cd_addr = int'(s_waddr); end
            if (!s_busy) break;
            @(posedge clk); #1;
        end
        check("sclr_first_cycle", first_cyc, 0);
        check("sclr_writes", cnt, 1280);
        check("sclr_order", bad, 0);
        check("sclr_done_cnt", cd_cnt, 1);
        check("sclr_done_addr", cd_addr, 1279);
        check("sclr_idle", int'(s_busy), 0);
        check("sclr_ready", int'(s_pt_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
